correlation_frame_loader: RTL and testbench
===========================================

# correlation_frame_loader

Front-end writer for the 10-tap correlator. It accepts a serial stream of 4-bit samples, assembles the coefficient vector h_0..h_9 and the sample window x_0..x_9, and presents each complete frame to the correlator through a valid/ready handshake. While a frame is outstanding it holds x and h stable. It sits between the sample source and the correlator's parallel x/h inputs.

## Interface
- DATA_W, 4: sample and coefficient width; tap count is fixed at 10.
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- s_data  in  DATA_W  incoming sample or coefficient.
- s_coef  in  1  1 = s_data is a coefficient, 0 = s_data is a data sample.
- s_valid  in  1  source has a word.
- s_ready  out  1  loader accepts the word this cycle; combinational: !f_valid && (s_coef || coef_ok).
- x_0..x_9  out  DATA_W each  sample window; x_0 holds the oldest sample.
- h_0..h_9  out  DATA_W each  coefficients; h_0 holds the first-loaded coefficient.
- f_valid  out  1  frame on x/h is complete and stable.
- f_ready  in  1  correlator takes the frame.
- coef_ok  out  1  all 10 coefficients loaded since the last coefficient reload.
- fill_count  out  4  data samples in the current window, 0..10.

## Operation
- Accept = s_valid && s_ready. Nothing changes without an accept or a frame transfer (f_valid && f_ready).
- Coefficient accept:
  - h shifts toward index 0 (h_k <= h_(k+1), h_9 <= s_data).
  - coef counter increments and saturates at 10; coef_ok = (count == 10).
  - If coef_ok was 1, the accepted word restarts loading: count becomes 1, coef_ok drops, fill_count clears to 0 (partial window discarded, x contents left as-is).
- Data accept (only possible when coef_ok = 1): x shifts the same way (x_9 <= s_data) and fill_count increments.
- States:
  - COEF: coef_ok = 0.
  - FILL: coef_ok = 1 and window incomplete.
  - PRESENT: f_valid = 1.
- Transitions:
  - COEF -> FILL on the 10th coefficient accept.
  - FILL -> PRESENT on the data accept that makes fill_count 10.
  - PRESENT -> FILL on frame transfer.
  - FILL -> COEF on a coefficient accept.
- PRESENT has no other exits: s_ready = 0 for both word types, so x/h cannot change under the correlator.
- Frame transfer in block mode: fill_count returns to 0.
- Reset (any cycle, including mid-load or PRESENT): all x_k, h_k = 0, f_valid = 0, coef_ok = 0, fill_count = 0, coef counter = 0, state COEF; s_ready = s_coef during reset-released cycles.

## Timing
- f_valid rises the cycle after the completing data accept. x_9 holds that sample in the same cycle.
- f_valid falls the cycle after the transfer. s_ready (data) is high again that same cycle.
- Block mode best case: 11 cycles per frame (10 accepts plus 1 present cycle with f_ready = 1).
- f_ready high together with a pending s_valid: the transfer completes first; the sample is accepted on the following cycle, never the same cycle.
- f_ready may be held high permanently, and may be asserted before f_valid. Neither case is an error.

## Configuration
- CORR_SLIDING_WINDOW_EN defined: after the first full window, fill_count stays at 10 on transfer. Every later data accept produces a new frame, giving a best case of 2 cycles per frame.
- CORR_SLIDING_WINDOW_EN undefined: block mode. Windows do not overlap and fill_count clears on transfer.

## Structure
- Shared package corr_pkg:
  - CORR_DATA_W = 4.
  - CORR_TAPS = 10.
  - State typedef {COEF, FILL, PRESENT}.
  - fill/coef counter width.
- Sub-module corr_shift_reg: 10-deep, DATA_W wide, shift-enable, parallel-out, synchronous clear. Instantiated twice, once for x and once for h.

## Test plan
- Reset, then 10 coefficients 1..10 with s_coef = 1 -> h_0 = 1, h_9 = 10, coef_ok = 1 after the 10th accept; data word with coef_ok = 0 sees s_ready = 0.
- Block mode, samples 0..9 with f_ready = 1 -> f_valid high for exactly 1 cycle the cycle after sample 9, x_0 = 0, x_9 = 9; the next 10 samples give a second frame 11 cycles later.
- f_ready = 0 for 5 cycles during PRESENT -> f_valid, x and h stable; s_ready = 0; the held sample is accepted the cycle after the transfer.
- Coefficient word after 4 data samples -> fill_count = 0, coef_ok = 0; after 9 more coefficients, a fresh 10 samples are required before f_valid.
- Sliding mode (macro defined), samples 0..12 with f_ready = 1 -> 4 frames; the last has x_0 = 3, x_9 = 12.
- Reset asserted in PRESENT -> next cycle f_valid = 0, all x/h = 0, coef_ok = 0, fill_count = 0.

Source files
------------

// File: rtl/corr_pkg.sv
// Shared types and constants for the 10-tap correlator frame loader.
// Used by the loader top, its shift registers and the handshake interface.
// Counters are sized to hold 0..CORR_TAPS inclusive.
package corr_pkg;
  localparam int CORR_DATA_W = 4;
  localparam int CORR_TAPS   = 10;
  localparam int CORR_CNT_W  = 4;

  typedef enum logic [1:0] {COEF, FILL, PRESENT} corr_state_t;

  typedef logic [CORR_CNT_W-1:0]                    corr_cnt_t;
  typedef logic [CORR_TAPS-1:0][CORR_DATA_W-1:0]    corr_taps_t;

  localparam corr_cnt_t CORR_FULL = corr_cnt_t'(CORR_TAPS);
  localparam corr_cnt_t CORR_LAST = corr_cnt_t'(CORR_TAPS - 1);
  localparam corr_cnt_t CORR_ONE  = corr_cnt_t'(1);
endpackage

// File: rtl/correlation_frame_loader_if.sv
// Handshake bundle between the sample source, the loader and the correlator.
// slave = loader side; master = source/correlator side (drives s_* inputs and f_ready).
// Element [k] of x/h is tap k; x[0] is the oldest sample, h[0] the first coefficient.
interface correlation_frame_loader_if;
  import corr_pkg::*;

  logic [CORR_DATA_W-1:0] s_data;
  logic                   s_coef;
  logic                   s_valid;
  logic                   s_ready;
  corr_taps_t             x;
  corr_taps_t             h;
  logic                   f_valid;
  logic                   f_ready;
  logic                   coef_ok;
  corr_cnt_t              fill_count;

  modport slave (
    input  s_data, s_coef, s_valid, f_ready,
    output s_ready, x, h, f_valid, coef_ok, fill_count
  );

  modport master (
    output s_data, s_coef, s_valid, f_ready,
    input  s_ready, x, h, f_valid, coef_ok, fill_count
  );
endinterface

// File: rtl/corr_shift_reg.sv
// DEPTH x W shift register, shifting toward index 0 with new data entering at DEPTH-1.
// Latency: one cycle from i_en to o_q; synchronous clear has priority over shift.
// No backpressure: the caller gates i_en.
module corr_shift_reg #(
  parameter int DEPTH = 10,
  parameter int W     = 4
) (
  input  logic                    i_clk,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic [W-1:0]            i_din,
  output logic [DEPTH-1:0][W-1:0] o_q
);
  logic [DEPTH-1:0][W-1:0] r_q;

  // Clear or shift one word in at the top; oldest word drops off index 0.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= {i_din, r_q[DEPTH-1:1]};
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/correlation_frame_loader.sv
// Assembles h_0..h_9 and x_0..x_9 from a serial 4-bit stream and presents frames to the correlator.
// Latency: f_valid rises the cycle after the completing data accept; a transfer frees the input next cycle.
// Backpressure: s_ready is low while a frame is presented; data words also wait until all coefficients are loaded.
// Optional: CORR_SLIDING_WINDOW_EN keeps the window full after a transfer so every new sample yields a frame.
module correlation_frame_loader
  import corr_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  correlation_frame_loader_if.slave   bus
);
  corr_state_t r_state, w_state_nxt;
  corr_cnt_t   r_coef_cnt;
  corr_cnt_t   r_fill_cnt;

  logic w_coef_ok;
  logic w_f_valid;
  logic w_s_ready;
  logic w_coef_acc;
  logic w_data_acc;
  logic w_xfer;

  assign w_coef_ok  = (r_coef_cnt == CORR_FULL);
  assign w_f_valid  = (r_state == PRESENT);
  assign w_s_ready  = !w_f_valid && (bus.s_coef || w_coef_ok);
  assign w_coef_acc = bus.s_valid && w_s_ready && bus.s_coef;
  assign w_data_acc = bus.s_valid && w_s_ready && !bus.s_coef;
  assign w_xfer     = w_f_valid && bus.f_ready;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= COEF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: coefficient reload always falls back to COEF; PRESENT only leaves on a transfer.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      COEF: begin
        if (w_coef_acc && (r_coef_cnt == CORR_LAST)) w_state_nxt = FILL;
      end
      FILL: begin
        if (w_coef_acc) begin
          w_state_nxt = COEF;
        end else if (w_data_acc && (r_fill_cnt >= CORR_LAST)) begin
          w_state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (w_xfer) w_state_nxt = FILL;
      end
      default: w_state_nxt = COEF;
    endcase
  end

  // Coefficient and window counters; a coefficient arriving after a full set restarts loading.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_coef_cnt <= '0;
      r_fill_cnt <= '0;
    end else if (w_xfer) begin
`ifdef CORR_SLIDING_WINDOW_EN
      r_fill_cnt <= r_fill_cnt;
`else
      r_fill_cnt <= '0;
`endif
    end else if (w_coef_acc) begin
      if (w_coef_ok) begin
        r_coef_cnt <= CORR_ONE;
        r_fill_cnt <= '0;
      end else begin
        r_coef_cnt <= r_coef_cnt + CORR_ONE;
      end
    end else if (w_data_acc) begin
      if (r_fill_cnt != CORR_FULL) r_fill_cnt <= r_fill_cnt + CORR_ONE;
    end
  end

  corr_shift_reg #(.DEPTH(CORR_TAPS), .W(CORR_DATA_W)) u_h_sr (
    .i_clk (clock),
    .i_clr (reset),
    .i_en  (w_coef_acc),
    .i_din (bus.s_data),
    .o_q   (bus.h)
  );

  corr_shift_reg #(.DEPTH(CORR_TAPS), .W(CORR_DATA_W)) u_x_sr (
    .i_clk (clock),
    .i_clr (reset),
    .i_en  (w_data_acc),
    .i_din (bus.s_data),
    .o_q   (bus.x)
  );

  assign bus.s_ready    = w_s_ready;
  assign bus.f_valid    = w_f_valid;
  assign bus.coef_ok    = w_coef_ok;
  assign bus.fill_count = r_fill_cnt;
endmodule

// File: tb/tb_correlation_frame_loader.sv
// Bench for correlation_frame_loader: directed vectors, array/queue reference model, per-cycle compare.
// Inputs change 1 time unit after posedge; outputs are compared on negedge.
module tb_correlation_frame_loader;
  import corr_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  correlation_frame_loader_if bus ();

  correlation_frame_loader dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the last ten coefficients and samples, plus counts.
  logic [3:0] mh [10];
  logic [3:0] mx [10];
  int  m_coef = 0;
  int  m_fill = 0;
  bit  m_fv = 0;
  bit  m_started = 0;

  function automatic bit m_rdy();
    return !m_fv && (bus.s_coef || (m_coef == 10));
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 10; k++) begin mh[k] = 0; mx[k] = 0; end
      m_coef = 0; m_fill = 0; m_fv = 0; m_started = 1;
    end else if (m_started) begin
      if (m_fv && bus.f_ready) begin
        m_fv = 0;
`ifndef CORR_SLIDING_WINDOW_EN
        m_fill = 0;
`endif
      end else if (bus.s_valid && m_rdy()) begin
        if (bus.s_coef) begin
          for (int k = 0; k < 9; k++) mh[k] = mh[k+1];
          mh[9] = bus.s_data;
          if (m_coef == 10) begin m_coef = 1; m_fill = 0; end
          else m_coef = m_coef + 1;
        end else begin
          for (int k = 0; k < 9; k++) mx[k] = mx[k+1];
          mx[9] = bus.s_data;
          if (m_fill < 10) m_fill = m_fill + 1;
          if (m_fill == 10) m_fv = 1;
        end
      end
    end
  end

  // Per-cycle compare plus frame-edge timestamps.
  int cyc = 0;
  int rise_q[$];
  int fall_q[$];
  logic prev_fv = 1'b0;

  always @(negedge clock) begin
    if (m_started) begin
      corr_taps_t ex, eh;
      for (int k = 0; k < 10; k++) begin ex[k] = mx[k]; eh[k] = mh[k]; end
      chk("s_ready",    64'(bus.s_ready),    64'(m_rdy()));
      chk("f_valid",    64'(bus.f_valid),    64'(m_fv));
      chk("coef_ok",    64'(bus.coef_ok),    64'(m_coef == 10));
      chk("fill_count", 64'(bus.fill_count), 64'(m_fill));
      chk("x",          64'(bus.x),          64'(ex));
      chk("h",          64'(bus.h),          64'(eh));
      if (bus.f_valid === 1'b1 && prev_fv !== 1'b1) rise_q.push_back(cyc);
      if (bus.f_valid === 1'b0 && prev_fv === 1'b1) fall_q.push_back(cyc);
      prev_fv = bus.f_valid;
      cyc++;
    end
  end

  task automatic drive(input bit v, input bit c, input logic [3:0] d, input bit fr);
    bus.s_valid = v; bus.s_coef = c; bus.s_data = d; bus.f_ready = fr;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Offer one word and hold it until accepted (bounded).
  task automatic send(input bit c, input logic [3:0] d, input bit fr);
    bit done = 0;
    drive(1'b1, c, d, fr);
    for (int t = 0; t < 40 && !done; t++) begin
      #1; done = bus.s_ready;
      @(posedge clock); #1;
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    reset = 1'b1;
    tick(); tick();
    // Reset state
    chk("rst_f_valid", 64'(bus.f_valid), 64'd0);
    chk("rst_coef_ok", 64'(bus.coef_ok), 64'd0);
    chk("rst_fill",    64'(bus.fill_count), 64'd0);
    chk("rst_x",       64'(bus.x), 64'd0);
    chk("rst_h",       64'(bus.h), 64'd0);
    drive(1'b0, 1'b1, 4'd0, 1'b0); #1;
    chk("rst_rdy_coef", 64'(bus.s_ready), 64'd1);
    drive(1'b0, 1'b0, 4'd0, 1'b0); #1;
    chk("rst_rdy_data", 64'(bus.s_ready), 64'd0);
    reset = 1'b0;
    tick();

    // Data word before coefficients are loaded is refused.
    drive(1'b1, 1'b0, 4'd7, 1'b0); #1;
    chk("nocoef_rdy", 64'(bus.s_ready), 64'd0);
    tick();
    chk("nocoef_fill", 64'(bus.fill_count), 64'd0);

    // Coefficients 1..10
    for (int i = 1; i <= 10; i++) begin
      send(1'b1, 4'(i), 1'b0);
      if (i == 9) chk("coef9_ok", 64'(bus.coef_ok), 64'd0);
    end
    chk("coef_ok",  64'(bus.coef_ok), 64'd1);
    chk("h0",       64'(bus.h[0]), 64'd1);
    chk("h9",       64'(bus.h[9]), 64'd10);
    rise_q.delete(); fall_q.delete();

`ifndef CORR_SLIDING_WINDOW_EN
    // Block mode streaming with f_ready held high: two frames 11 cycles apart.
    for (int i = 0; i < 20; i++) begin
      send(1'b0, 4'(i), 1'b1);
      if (i == 9) begin
        chk("blk_fv",  64'(bus.f_valid), 64'd1);
        chk("blk_x0",  64'(bus.x[0]), 64'd0);
        chk("blk_x9",  64'(bus.x[9]), 64'd9);
      end
      if (i == 10) chk("blk_fill_after", 64'(bus.fill_count), 64'd1);
    end
    drive(1'b0, 1'b0, 4'd0, 1'b1);
    tick(); tick();
    chk("blk_frames", 64'(rise_q.size()), 64'd2);
    if (rise_q.size() >= 2 && fall_q.size() >= 1) begin
      chk("blk_period", 64'(rise_q[1] - rise_q[0]), 64'd11);
      chk("blk_width",  64'(fall_q[0] - rise_q[0]), 64'd1);
    end else begin
      chk("blk_edges", 64'(fall_q.size()), 64'd2);
    end

    // Stall in PRESENT for 5 cycles with a sample waiting.
    for (int i = 20; i < 30; i++) send(1'b0, 4'(i), 1'b0);
    drive(1'b1, 1'b0, 4'd14, 1'b0);
    for (int t = 0; t < 5; t++) begin
      #1;
      chk("stall_rdy", 64'(bus.s_ready), 64'd0);
      chk("stall_fv",  64'(bus.f_valid), 64'd1);
      chk("stall_x0",  64'(bus.x[0]), 64'd4);
      chk("stall_x9",  64'(bus.x[9]), 64'd13);
      chk("stall_h9",  64'(bus.h[9]), 64'd10);
      tick();
    end
    bus.f_ready = 1'b1;
    tick();
    chk("xfer_fv",   64'(bus.f_valid), 64'd0);
    chk("xfer_fill", 64'(bus.fill_count), 64'd0);
    chk("xfer_rdy",  64'(bus.s_ready), 64'd1);
    bus.f_ready = 1'b0;
    tick();
    chk("held_fill", 64'(bus.fill_count), 64'd1);
    chk("held_x9",   64'(bus.x[9]), 64'd14);

    // Coefficient reload after 4 samples discards the partial window.
    for (int i = 31; i < 34; i++) send(1'b0, 4'(i), 1'b0);
    chk("part_fill", 64'(bus.fill_count), 64'd4);
    send(1'b1, 4'd5, 1'b0);
    chk("reload_ok",   64'(bus.coef_ok), 64'd0);
    chk("reload_fill", 64'(bus.fill_count), 64'd0);
    for (int i = 6; i <= 14; i++) send(1'b1, 4'(i), 1'b0);
    chk("reload_ok2", 64'(bus.coef_ok), 64'd1);
    chk("reload_h0",  64'(bus.h[0]), 64'd5);
    chk("reload_h9",  64'(bus.h[9]), 64'd14);
    for (int i = 0; i < 9; i++) send(1'b0, 4'(i), 1'b0);
    chk("fresh9_fv", 64'(bus.f_valid), 64'd0);
    send(1'b0, 4'd9, 1'b0);
    chk("fresh10_fv", 64'(bus.f_valid), 64'd1);
`else
    // Sliding mode: samples 0..12 give four frames, the last holding 3..12.
    for (int i = 0; i <= 12; i++) send(1'b0, 4'(i), 1'b1);
    chk("sld_fv", 64'(bus.f_valid), 64'd1);
    chk("sld_x0", 64'(bus.x[0]), 64'd3);
    chk("sld_x9", 64'(bus.x[9]), 64'd12);
    drive(1'b0, 1'b0, 4'd0, 1'b1);
    tick(); tick();
    chk("sld_frames", 64'(rise_q.size()), 64'd4);
    chk("sld_fill",   64'(bus.fill_count), 64'd10);
    send(1'b0, 4'd13, 1'b0);
    chk("sld_fv2", 64'(bus.f_valid), 64'd1);
`endif

    // Reset while a frame is presented.
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstp_fv",   64'(bus.f_valid), 64'd0);
    chk("rstp_x",    64'(bus.x), 64'd0);
    chk("rstp_h",    64'(bus.h), 64'd0);
    chk("rstp_ok",   64'(bus.coef_ok), 64'd0);
    chk("rstp_fill", 64'(bus.fill_count), 64'd0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
